// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one 16-bit memory/IO port between the prefetch
// (instr_m_*) and load/store (data_m_*) masters. Data has priority. A grant
// is held until the owner is acked or the owner aborts, and an IDLE
// turnaround cycle always separates two grants.
// Optional feature macro: MEM_ARB_STARVE_GUARD_EN. When it is defined,
// prefetch is granted after STARVE_LIMIT consecutive data grants that it
// spent waiting for.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  // prefetch master
  input  logic [19:1] instr_m_addr,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  output logic [15:0] instr_m_data_in,
  // load/store master
  input  logic [19:1] data_m_addr,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  input  logic        d_io,
  output logic        data_m_ack,
  output logic [15:0] data_m_data_in,
  // shared memory port
  output logic [19:1] q_m_addr,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel,
  output logic        q_m_io,
  input  logic [15:0] q_m_data_in,
  input  logic        q_m_ack
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_DATA  = 2'd1,
    GRANT_INSTR = 2'd2
  } state_t;

  state_t r_state;
  logic   w_pick_instr;

  // Reject a starvation limit that does not fit the 4-bit counter
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("mem_bus_arbiter: STARVE_LIMIT must be in 1..15");
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned     CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;

  // Prefetch wins a tie once data has used up its quota of grants
  assign w_pick_instr = instr_m_access &&
                        (!data_m_access || (r_starve_cnt == LIMIT));

  // Count data grants that prefetch had to wait behind; saturates at the limit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (!instr_m_access || w_pick_instr) begin
        r_starve_cnt <= '0;
      end else if (data_m_access && (r_starve_cnt != LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end
`else
  // Strict data priority: prefetch only wins when data is not asking
  assign w_pick_instr = instr_m_access && !data_m_access;
`endif

  // Grant state: arbitrate in IDLE, hold ownership until ack or abort
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_instr) begin
            r_state <= GRANT_INSTR;
          end else if (data_m_access) begin
            r_state <= GRANT_DATA;
          end
        end
        GRANT_DATA: begin
          if (q_m_ack || !data_m_access) begin
            r_state <= IDLE;
          end
        end
        GRANT_INSTR: begin
          if (q_m_ack || !instr_m_access) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Steer the owner's request onto the shared port and route the ack back
  always_comb begin
    q_m_addr     = '0;
    q_m_data_out = '0;
    q_m_access   = 1'b0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    q_m_io       = 1'b0;
    instr_m_ack  = 1'b0;
    data_m_ack   = 1'b0;
    case (r_state)
      GRANT_DATA: begin
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_access   = data_m_access;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        q_m_io       = d_io;
        data_m_ack   = q_m_ack;
      end
      GRANT_INSTR: begin
        q_m_addr     = instr_m_addr;
        q_m_access   = instr_m_access;
        q_m_bytesel  = 2'b11;
        instr_m_ack  = q_m_ack;
      end
      default: ;
    endcase
  end

  // Read data goes to both masters; only the ack qualifies it
  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus a randomized phase, checked
// cycle by cycle against a transaction-level ownership model of the arbiter.
module tb_mem_bus_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam int NONE = 0;
  localparam int DMST = 1;
  localparam int IMST = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:1] instr_m_addr = '0;
  logic        instr_m_access = 1'b0;
  logic        instr_m_ack;
  logic [15:0] instr_m_data_in;
  logic [19:1] data_m_addr = '0;
  logic [15:0] data_m_data_out = '0;
  logic        data_m_access = 1'b0;
  logic        data_m_wr_en = 1'b0;
  logic [1:0]  data_m_bytesel = '0;
  logic        d_io = 1'b0;
  logic        data_m_ack;
  logic [15:0] data_m_data_in;
  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_out;
  logic        q_m_access;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_m_io;
  logic [15:0] q_m_data_in = '0;
  logic        q_m_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // model: who owns the port, and how many data grants prefetch has sat through
  int m_owner = NONE;
  int m_streak = 0;

  mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
    .instr_m_ack(instr_m_ack), .instr_m_data_in(instr_m_data_in),
    .data_m_addr(data_m_addr), .data_m_data_out(data_m_data_out),
    .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
    .data_m_bytesel(data_m_bytesel), .d_io(d_io),
    .data_m_ack(data_m_ack), .data_m_data_in(data_m_data_in),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out),
    .q_m_access(q_m_access), .q_m_wr_en(q_m_wr_en),
    .q_m_bytesel(q_m_bytesel), .q_m_io(q_m_io),
    .q_m_data_in(q_m_data_in), .q_m_ack(q_m_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Ownership rules applied at each rising edge to the inputs of the ending cycle
  function automatic void model_edge();
    bool_t_dummy();
    if (m_owner != NONE) begin
      if (q_m_ack) m_owner = NONE;
      else if (m_owner == DMST && !data_m_access) m_owner = NONE;
      else if (m_owner == IMST && !instr_m_access) m_owner = NONE;
    end else begin
      if (instr_m_access && (!data_m_access || (GUARD && m_streak == int'(LIMIT)))) begin
        m_owner  = IMST;
        m_streak = 0;
      end else if (data_m_access) begin
        m_owner = DMST;
        if (instr_m_access && m_streak < int'(LIMIT)) m_streak++;
      end
      if (!instr_m_access) m_streak = 0;
    end
  endfunction

  function automatic void bool_t_dummy();
  endfunction

  function automatic logic exp_access();
    if (m_owner == DMST) return data_m_access;
    if (m_owner == IMST) return instr_m_access;
    return 1'b0;
  endfunction

  task automatic check_all(input string tag);
    logic [18:0] e_addr = '0;
    logic [15:0] e_dout = '0;
    logic        e_acc = 1'b0, e_wr = 1'b0, e_io = 1'b0, e_iack = 1'b0, e_dack = 1'b0;
    logic [1:0]  e_bs = 2'b00;
    if (m_owner == DMST) begin
      e_addr = data_m_addr; e_dout = data_m_data_out; e_acc = data_m_access;
      e_wr = data_m_wr_en; e_bs = data_m_bytesel; e_io = d_io; e_dack = q_m_ack;
    end else if (m_owner == IMST) begin
      e_addr = instr_m_addr; e_acc = instr_m_access; e_bs = 2'b11; e_iack = q_m_ack;
    end
    chk({tag, ".acc"},  32'(q_m_access),  32'(e_acc));
    chk({tag, ".addr"}, 32'(q_m_addr),    32'(e_addr));
    chk({tag, ".dout"}, 32'(q_m_data_out), 32'(e_dout));
    chk({tag, ".wr"},   32'(q_m_wr_en),   32'(e_wr));
    chk({tag, ".bs"},   32'(q_m_bytesel), 32'(e_bs));
    chk({tag, ".io"},   32'(q_m_io),      32'(e_io));
    chk({tag, ".iack"}, 32'(instr_m_ack), 32'(e_iack));
    chk({tag, ".dack"}, 32'(data_m_ack),  32'(e_dack));
    chk({tag, ".idin"}, 32'(instr_m_data_in), 32'(q_m_data_in));
    chk({tag, ".ddin"}, 32'(data_m_data_in),  32'(q_m_data_in));
  endtask

  // Advance to just after the next rising edge, updating the model
  task automatic tick();
    @(posedge clk);
    if (!reset_n) begin
      m_owner = NONE; m_streak = 0;
    end else begin
      model_edge();
    end
    #1;
  endtask

  // Sample mid-cycle on the falling edge
  task automatic settle(input string tag);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    instr_m_access = 1'b0; data_m_access = 1'b0; data_m_wr_en = 1'b0;
    data_m_bytesel = 2'b00; d_io = 1'b0; data_m_data_out = '0;
    q_m_ack = 1'b0; q_m_data_in = '0;
    m_owner = NONE; m_streak = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int ngr;
    int n_instr;
    int gseq[50];
    logic d_done, i_done;

    // reset with both requesting: nothing reaches the port
    instr_m_addr = 19'h00111; data_m_addr = 19'h0ABCD;
    instr_m_access = 1'b1; data_m_access = 1'b1;
    #2;
    chk("rst.acc", 32'(q_m_access), 32'd0);
    chk("rst.iack", 32'(instr_m_ack), 32'd0);
    chk("rst.dack", 32'(data_m_ack), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    settle("rst.rel");
    tick(); settle("rst.g1");
    chk("rst.first_data", 32'(q_m_addr), 32'h0ABCD);
    chk("rst.first_acc", 32'(q_m_access), 32'd1);

    // single prefetch
    do_reset();
    instr_m_addr = 19'h12345; instr_m_access = 1'b1;
    settle("sp.c0");
    chk("sp.c0acc", 32'(q_m_access), 32'd0);
    tick(); settle("sp.c1");
    chk("sp.c1acc", 32'(q_m_access), 32'd1);
    chk("sp.c1bs", 32'(q_m_bytesel), 32'd3);
    tick(); settle("sp.c2");
    tick(); q_m_ack = 1'b1; q_m_data_in = 16'hBEEF; settle("sp.c3");
    chk("sp.iack", 32'(instr_m_ack), 32'd1);
    chk("sp.idata", 32'(instr_m_data_in), 32'hBEEF);
    chk("sp.dack", 32'(data_m_ack), 32'd0);
    tick(); instr_m_access = 1'b0; q_m_ack = 1'b0; settle("sp.c4");
    chk("sp.c4acc", 32'(q_m_access), 32'd0);

    // simultaneous: data store to IO first, then prefetch after one idle cycle
    do_reset();
    instr_m_addr = 19'h00100; instr_m_access = 1'b1;
    data_m_addr = 19'h7FFFF; data_m_access = 1'b1; data_m_wr_en = 1'b1;
    data_m_data_out = 16'hA55A; data_m_bytesel = 2'b01; d_io = 1'b1;
    settle("sim.c0");
    tick(); settle("sim.c1");
    chk("sim.wr", 32'(q_m_wr_en), 32'd1);
    chk("sim.io", 32'(q_m_io), 32'd1);
    chk("sim.dout", 32'(q_m_data_out), 32'hA55A);
    chk("sim.bs", 32'(q_m_bytesel), 32'd1);
    tick(); q_m_ack = 1'b1; settle("sim.c2");
    chk("sim.dack", 32'(data_m_ack), 32'd1);
    tick(); data_m_access = 1'b0; q_m_ack = 1'b0; settle("sim.c3");
    chk("sim.turn", 32'(q_m_access), 32'd0);
    tick(); settle("sim.c4");
    chk("sim.iaddr", 32'(q_m_addr), 32'h00100);
    chk("sim.iwr", 32'(q_m_wr_en), 32'd0);
    tick(); q_m_ack = 1'b1; settle("sim.c5");
    tick(); instr_m_access = 1'b0; q_m_ack = 1'b0; settle("sim.c6");

    // no preemption of a granted prefetch
    do_reset();
    instr_m_addr = 19'h22222; instr_m_access = 1'b1;
    data_m_addr = 19'h33333; data_m_wr_en = 1'b0; data_m_bytesel = 2'b10;
    settle("np.c0");
    tick(); data_m_access = 1'b1; settle("np.c1");
    chk("np.hold1", 32'(q_m_addr), 32'h22222);
    tick(); settle("np.c2");
    chk("np.hold2", 32'(q_m_addr), 32'h22222);
    tick(); q_m_ack = 1'b1; settle("np.c3");
    tick(); instr_m_access = 1'b0; q_m_ack = 1'b0; settle("np.c4");
    tick(); settle("np.c5");
    chk("np.data", 32'(q_m_addr), 32'h33333);
    tick(); q_m_ack = 1'b1; settle("np.c6");
    tick(); data_m_access = 1'b0; q_m_ack = 1'b0; settle("np.c7");

    // owner abort: port request drops at once, no ack, IDLE next
    do_reset();
    data_m_addr = 19'h04444; data_m_access = 1'b1;
    settle("ab.c0");
    tick(); settle("ab.c1");
    tick(); data_m_access = 1'b0; settle("ab.c2");
    chk("ab.acc", 32'(q_m_access), 32'd0);
    chk("ab.dack", 32'(data_m_ack), 32'd0);
    tick(); settle("ab.c3");

    // reset while granted drops the request asynchronously
    do_reset();
    instr_m_addr = 19'h05555; instr_m_access = 1'b1;
    settle("rm.c0");
    tick(); settle("rm.c1");
    tick(); reset_n = 1'b0; #1;
    chk("rm.acc", 32'(q_m_access), 32'd0);
    chk("rm.iack", 32'(instr_m_ack), 32'd0);

    // starvation: both hold requests, memory acks immediately
    do_reset();
    instr_m_addr = 19'h06666; data_m_addr = 19'h07777;
    instr_m_access = 1'b1; data_m_access = 1'b1;
    ngr = 0;
    settle("st.c0");
    for (int c = 0; c < 400 && ngr < 50; c++) begin
      tick();
      q_m_ack = exp_access();
      settle("st");
      if (instr_m_ack) begin gseq[ngr] = IMST; ngr++; end
      else if (data_m_ack) begin gseq[ngr] = DMST; ngr++; end
    end
    chk("st.transfers", 32'(ngr), 32'd50);
    n_instr = 0;
    for (int i = 0; i < ngr; i++) begin
      if (gseq[i] == IMST) n_instr++;
`ifdef MEM_ARB_STARVE_GUARD_EN
      chk($sformatf("st.order%0d", i), 32'(gseq[i]), (i % 5 == 4) ? 32'(IMST) : 32'(DMST));
`endif
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("st.ngrants", 32'(n_instr), 32'd10);
`else
    chk("st.ngrants", 32'(n_instr), 32'd0);
`endif

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      d_done = (m_owner == DMST) && q_m_ack;
      i_done = (m_owner == IMST) && q_m_ack;
      tick();
      if (!data_m_access || d_done) begin
        data_m_access = (data_m_access && d_done) ? $urandom_range(0, 1) == 1
                                                  : $urandom_range(0, 2) == 0;
        data_m_addr = 19'($urandom); data_m_data_out = 16'($urandom);
        data_m_wr_en = 1'($urandom); data_m_bytesel = 2'($urandom); d_io = 1'($urandom);
      end else if ($urandom_range(0, 40) == 0) begin
        data_m_access = 1'b0;
      end
      if (!instr_m_access || i_done) begin
        instr_m_access = (instr_m_access && i_done) ? $urandom_range(0, 1) == 1
                                                    : $urandom_range(0, 2) == 0;
        instr_m_addr = 19'($urandom);
      end else if ($urandom_range(0, 40) == 0) begin
        instr_m_access = 1'b0;
      end
      q_m_data_in = 16'($urandom);
      q_m_ack = exp_access() && ($urandom_range(0, 2) == 0);
      settle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
